// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle arithmetic/logic/compare ops, an iterative
// 1-bit/cycle shifter for SLL/SRL/SRA, and valid/ready handshakes on both the
// operand side and the result side. All outputs except in_ready are registered.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cmp_true,
    output logic            illegal
);

    // ALU_OP_* codes shared with the ALU control decoder
    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OP_OR   = 4'b0110;
    localparam logic [3:0] ALU_OP_AND  = 4'b0111;
    localparam logic [3:0] ALU_OP_EQ   = 4'b1001;
    localparam logic [3:0] ALU_OP_NEQ  = 4'b1010;
    localparam logic [3:0] ALU_OP_GE   = 4'b1100;
    localparam logic [3:0] ALU_OP_GEU  = 4'b1110;
    localparam logic [3:0] ALU_OP_XXX  = 4'b1111;

    // Shift flavour remembered while iterating
    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   shreg_r;
    logic [SHW-1:0]    count_r;
    logic [1:0]        shkind_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   result_r;
    logic              cmp_true_r;
    logic              illegal_r;

    logic [XLEN-1:0]   res_s;
    logic              cmp_s;
    logic              ill_s;
    logic              shift_s;
    logic [1:0]        shkind_s;
    logic [SHW-1:0]    shamt_s;
    logic              accept_s;
    logic [XLEN-1:0]   shnext_s;

    assign shamt_s  = op_b[SHW-1:0];
    // A held result may be replaced in the same cycle it is consumed
    assign in_ready = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s = in_valid & in_ready;

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cmp_true  = cmp_true_r;
    assign illegal   = illegal_r;

    // Decode the incoming op and compute the single-cycle result
    always_comb begin
        res_s    = '0;
        cmp_s    = 1'b0;
        ill_s    = 1'b0;
        shift_s  = 1'b0;
        shkind_s = SH_LL;
        case (alu_op)
            ALU_OP_ADD:  res_s = op_a + op_b;
            ALU_OP_SUB:  res_s = op_a - op_b;
            ALU_OP_XOR:  res_s = op_a ^ op_b;
            ALU_OP_OR:   res_s = op_a | op_b;
            ALU_OP_AND:  res_s = op_a & op_b;
            // a zero shift amount finishes immediately with op_a unchanged
            ALU_OP_SLL: begin
                shift_s  = 1'b1;
                shkind_s = SH_LL;
                res_s    = op_a;
            end
            ALU_OP_SRL: begin
                shift_s  = 1'b1;
                shkind_s = SH_RL;
                res_s    = op_a;
            end
            ALU_OP_SRA: begin
                shift_s  = 1'b1;
                shkind_s = SH_RA;
                res_s    = op_a;
            end
            ALU_OP_SLT: begin
                cmp_s = ($signed(op_a) < $signed(op_b));
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_SLTU: begin
                cmp_s = (op_a < op_b);
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_EQ: begin
                cmp_s = (op_a == op_b);
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_NEQ: begin
                cmp_s = (op_a != op_b);
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_GE: begin
                cmp_s = ($signed(op_a) >= $signed(op_b));
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_GEU: begin
                cmp_s = (op_a >= op_b);
                res_s = {{(XLEN-1){1'b0}}, cmp_s};
            end
            ALU_OP_XXX:  res_s = '0;
            default:     ill_s = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        shnext_s = shreg_r;
        case (shkind_r)
            SH_LL:   shnext_s = {shreg_r[XLEN-2:0], 1'b0};
            SH_RL:   shnext_s = {1'b0, shreg_r[XLEN-1:1]};
            SH_RA:   shnext_s = {shreg_r[XLEN-1], shreg_r[XLEN-1:1]};
            default: shnext_s = shreg_r;
        endcase
    end

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shreg_r     <= '0;
            count_r     <= '0;
            shkind_r    <= SH_LL;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            cmp_true_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (shift_s && (shamt_s != '0)) begin
                            state_r     <= ST_SHIFT;
                            out_valid_r <= 1'b0;
                            shreg_r     <= op_a;
                            count_r     <= shamt_s;
                            shkind_r    <= shkind_s;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= res_s;
                            cmp_true_r  <= cmp_s;
                            illegal_r   <= ill_s;
                        end
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shnext_s;
                    count_r <= count_r - SHW'(1);
                    if (count_r == SHW'(1)) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shnext_s;
                        cmp_true_r  <= 1'b0;
                        illegal_r   <= 1'b0;
                    end else begin
                        state_r     <= ST_SHIFT;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU. Consumes the 4-bit aluOp produced by the ALU control decoder, together with two operands.
- Produces a registered result and a compare/branch flag behind valid/ready handshakes.
- Shifts use an iterative 1-bit/cycle shifter to save area; every other op completes in one cycle.
- Sits between decode/regfile read and the writeback/branch-resolve logic.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op/operands valid.
- in_ready  out  1  block can accept an op.
- alu_op  in  4  ALU_OP_* code from the shared defines file.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  ALU result.
- cmp_true  out  1  comparison outcome for EQ/NEQ/SLT/SLTU/GE/GEU; 0 otherwise.
- illegal  out  1  the accepted alu_op was not a defined code.

Behaviour:
- Reset is asynchronous, active-low: one clock (clk), reset rst_n.

Op encodings:
- ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- EQ, NEQ, GE, GEU and XXX use their ALU_OP_* macro values from the defines file.
- Any other code is illegal.

State machine:
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, out_valid=0, result=0, cmp_true=0, illegal=0, internal shift count=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational, so it reads 1 while held in reset; inputs are ignored while rst_n=0.
- Accept occurs when in_valid & in_ready at a rising edge, cycle T.

Non-shift op:
- result, cmp_true and illegal are registered at T.
- State goes to DONE, so out_valid=1 from T+1. Latency is 1.

Shift op (SLL/SRL/SRA):
- Shift amount N = op_b[SHW-1:0]; upper bits of op_b are ignored.
- N=0: DONE at T+1 with result=op_a.
- N>0: enter SHIFT with shift reg=op_a and count=N. Each SHIFT cycle shifts 1 bit and decrements count.
  - SLL/SRL fill with 0; SRA fills with op_a[XLEN-1].
- When count reaches 0, go to DONE. out_valid rises at T+1+N.
- out_valid=0 and result is don't-care-stable (holds last value) during SHIFT.

Arithmetic:
- ADD/SUB wrap modulo 2^XLEN.
- SLT and GE are signed; SLTU and GEU are unsigned.
- Compare ops return result={XLEN-1 zeros, cmp} and cmp_true=cmp.
- Logical ops and shifts return cmp_true=0.

Illegal op:
- Completes in 1 cycle with result=0, cmp_true=0, illegal=1.
- No other side effect.

DONE state:
- result, cmp_true and illegal are held stable while out_valid=1 & out_ready=0.
- On out_valid & out_ready:
  - if a new op is accepted in the same cycle, the next state follows that op's rules (back-to-back, no bubble);
  - otherwise go to IDLE and drop out_valid.

Reset mid-operation:
- Aborts any SHIFT/DONE immediately and returns to reset values.
- The pending result is discarded.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 accepted at T -> out_valid at T+1, result=0x80000000, cmp_true=0, illegal=0.
- SUB 0x00000000 - 0x00000001 -> result=0xFFFFFFFF. SLT with a=0xFFFFFFFF, b=0x00000001 -> result=1, cmp_true=1. SLTU with the same operands -> result=0, cmp_true=0.
- SRA with a=0x80000000, b=0x00000024 (N=4) -> in_ready=0 for cycles T+1..T+4, out_valid at T+5, result=0xF8000000. SLL with N=0 -> out_valid at T+1, result=op_a.
- Backpressure: hold out_ready=0 for 3 cycles after an EQ on 5,5 -> out_valid stays 1, result=1, cmp_true=1 stable. Then assert out_ready together with in_valid for an XOR 0xF0F0,0xFF00 -> next cycle result=0x00000FF0 with no bubble.
- Illegal alu_op -> out_valid at T+1, illegal=1, result=0. The next legal op clears illegal.
- Drop rst_n during SRL N=20 at shift cycle 7 -> out_valid=0, result=0, in_ready=1 immediately. After release, a fresh ADD 2+3 gives result=5 at T+1.
